// File: rtl/demux4_deser_pkg.sv
// Shared lane constants and helpers for the four-lane deserializer.
// Imported by the top and by the per-lane storage module.
package demux4_deser_pkg;

   localparam int NUM_LANES = 4;
   localparam int LANE_W    = 2;

   typedef logic [LANE_W-1:0] lane_idx_t;

   localparam logic [NUM_LANES-1:0] FRAME_FULL = 4'b1111;

   function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_idx_t idx);
      logic [NUM_LANES-1:0] mask;
      mask      = '0;
      mask[idx] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/demux4_lane.sv
// One output lane: a data register plus its "written since last frame" flag.
// The clear only drops the flag; the data is held for downstream use.
module demux4_lane #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         we_i,
   input  logic         clr_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] data_o,
   output logic         full_o
);

   logic [W-1:0] data_q, data_d;
   logic         full_q, full_d;

   // A write and a clear on the same edge still store the data: this is how
   // the completing word of a frame lands while the flags are emptied.
   always_comb begin
      data_d = data_q;
      full_d = full_q;
      if (we_i) begin
         data_d = d_i;
         full_d = 1'b1;
      end
      if (clr_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
      end
   end

   assign data_o = data_q;
   assign full_o = full_q;

endmodule

// File: rtl/demux4_deser.sv
// Four-lane registered demultiplexer: steers IN onto OUT0..OUT3 round-robin or
// by Select, and pulses Frame_Valid when all four lanes have been written.
module demux4_deser
   import demux4_deser_pkg::*;
#(
   parameter int bw_in = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [bw_in-1:0] IN,
   input  logic             IN_Valid,
   input  logic             Auto,
   input  logic [1:0]       Select,
   input  logic             Clear,
   output logic [bw_in-1:0] OUT0,
   output logic [bw_in-1:0] OUT1,
   output logic [bw_in-1:0] OUT2,
   output logic [bw_in-1:0] OUT3,
   output logic [3:0]       Lane_Full,
   output logic             Frame_Valid,
   output logic             Overrun
);

   lane_idx_t            pointer_q, pointer_d;
   logic                 frame_valid_q, frame_valid_d;
   logic                 overrun_q, overrun_d;

   lane_idx_t            target;
   logic                 wr_en;
   logic [NUM_LANES-1:0] wr_mask;
   logic [NUM_LANES-1:0] full_vec;
   logic                 frame_done;
   logic                 overrun_hit;
   logic                 lane_clr;
   logic [bw_in-1:0]     lane_data [NUM_LANES];

   // Clear wins over a simultaneous write, so it gates the write enable.
   always_comb begin
      target      = Auto ? pointer_q : lane_idx_t'(Select);
      wr_en       = IN_Valid & ~Clear;
      wr_mask     = wr_en ? lane_onehot(target) : '0;
      frame_done  = wr_en && ((full_vec | lane_onehot(target)) == FRAME_FULL);
      overrun_hit = wr_en && full_vec[target];
      lane_clr    = Clear | frame_done;
   end

   always_comb begin
      pointer_d     = pointer_q;
      frame_valid_d = frame_done;
      overrun_d     = overrun_q | overrun_hit;
      if (Clear) begin
         pointer_d = '0;
         overrun_d = 1'b0;
      end else if (wr_en && Auto) begin
         pointer_d = lane_idx_t'(pointer_q + 1'b1);
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         pointer_q     <= '0;
         frame_valid_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         pointer_q     <= pointer_d;
         frame_valid_q <= frame_valid_d;
         overrun_q     <= overrun_d;
      end
   end

   for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
      demux4_lane #(
         .W(bw_in)
      ) u_lane (
         .clk_i  (Clock),
         .rst_i  (Reset),
         .we_i   (wr_mask[n]),
         .clr_i  (lane_clr),
         .d_i    (IN),
         .data_o (lane_data[n]),
         .full_o (full_vec[n])
      );
   end

   assign OUT0        = lane_data[0];
   assign OUT1        = lane_data[1];
   assign OUT2        = lane_data[2];
   assign OUT3        = lane_data[3];
   assign Lane_Full   = full_vec;
   assign Frame_Valid = frame_valid_q;
   assign Overrun     = overrun_q;

endmodule

// File: tb/tb_demux4_deser.sv
// Self-checking bench for demux4_deser: scenario tasks with inline checks and
// a frame scoreboard popped whenever Frame_Valid is seen.
module tb_demux4_deser;

   logic       Clock = 1'b0;
   logic       Reset;
   logic [3:0] IN;
   logic       IN_Valid;
   logic       Auto;
   logic [1:0] Select;
   logic       Clear;
   logic [3:0] OUT0, OUT1, OUT2, OUT3;
   logic [3:0] Lane_Full;
   logic       Frame_Valid;
   logic       Overrun;

   int total = 0;
   int bad   = 0;

   logic [15:0] exp_q[$];

   demux4_deser #(.bw_in(4)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .IN          (IN),
      .IN_Valid    (IN_Valid),
      .Auto        (Auto),
      .Select      (Select),
      .Clear       (Clear),
      .OUT0        (OUT0),
      .OUT1        (OUT1),
      .OUT2        (OUT2),
      .OUT3        (OUT3),
      .Lane_Full   (Lane_Full),
      .Frame_Valid (Frame_Valid),
      .Overrun     (Overrun)
   );

   always #5 Clock = ~Clock;

   // Frame scoreboard: each Frame_Valid pulse must match the oldest expected frame.
   always @(negedge Clock) begin
      if (Frame_Valid === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL frame_unexpected got=%h required=none", {OUT3, OUT2, OUT1, OUT0});
         end else begin
            logic [15:0] exp_frame;
            exp_frame = exp_q.pop_front();
            if ({OUT3, OUT2, OUT1, OUT0} !== exp_frame) begin
               bad++;
               $display("FAIL frame_data got=%h required=%h", {OUT3, OUT2, OUT1, OUT0}, exp_frame);
            end
         end
      end
   end

   // Drive one cycle of inputs, then return to idle just after the edge.
   task automatic drive(input logic v, input logic a, input logic [1:0] s,
                        input logic c, input logic [3:0] d);
      IN_Valid = v;
      Auto     = a;
      Select   = s;
      Clear    = c;
      IN       = d;
      @(posedge Clock);
      #1;
      IN_Valid = 1'b0;
      Clear    = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge Clock);
      #1;
      total++;
      if ({OUT3, OUT2, OUT1, OUT0, Lane_Full, Frame_Valid, Overrun} !== 22'd0) begin
         bad++;
         $display("FAIL reset_state got=%h required=0",
                  {OUT3, OUT2, OUT1, OUT0, Lane_Full, Frame_Valid, Overrun});
      end
      Reset = 1'b0;
      @(posedge Clock);
      #1;
   endtask

   task automatic test_auto_frame();
      drive(1'b1, 1'b1, 2'd0, 1'b0, 4'd1);
      drive(1'b1, 1'b1, 2'd0, 1'b0, 4'd2);
      drive(1'b1, 1'b1, 2'd0, 1'b0, 4'd3);
      total++;
      if (Lane_Full !== 4'b0111 || Frame_Valid !== 1'b0) begin
         bad++;
         $display("FAIL auto_partial got=%b/%b required=0111/0", Lane_Full, Frame_Valid);
      end
      exp_q.push_back({4'd4, 4'd3, 4'd2, 4'd1});
      drive(1'b1, 1'b1, 2'd0, 1'b0, 4'd4);
      total++;
      if (Frame_Valid !== 1'b1 || Lane_Full !== 4'b0000) begin
         bad++;
         $display("FAIL auto_frame got=%b/%b required=1/0000", Frame_Valid, Lane_Full);
      end
      total++;
      if ({OUT0, OUT1, OUT2, OUT3} !== 16'h1234) begin
         bad++;
         $display("FAIL auto_outs got=%h required=1234", {OUT0, OUT1, OUT2, OUT3});
      end
      drive(1'b0, 1'b1, 2'd0, 1'b0, 4'd0);
      total++;
      if (Frame_Valid !== 1'b0) begin
         bad++;
         $display("FAIL auto_pulse_width got=%b required=0", Frame_Valid);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 12; i++) begin
         if (i % 4 == 0)
            exp_q.push_back({4'(i), 4'(i - 1), 4'(i - 2), 4'(i - 3)});
         drive(1'b1, 1'b1, 2'd0, 1'b0, 4'(i));
         total++;
         if (Frame_Valid !== (i % 4 == 0)) begin
            bad++;
            $display("FAIL stream_pulse word=%0d got=%b required=%b", i, Frame_Valid, (i % 4 == 0));
         end
      end
      total++;
      if ({OUT0, OUT1, OUT2, OUT3} !== 16'h9ABC || Overrun !== 1'b0) begin
         bad++;
         $display("FAIL stream_end got=%h/%b required=9abc/0", {OUT0, OUT1, OUT2, OUT3}, Overrun);
      end
   endtask

   task automatic test_select();
      drive(1'b1, 1'b0, 2'd2, 1'b0, 4'hA);
      drive(1'b1, 1'b0, 2'd0, 1'b0, 4'hB);
      drive(1'b1, 1'b0, 2'd3, 1'b0, 4'hC);
      total++;
      if (Frame_Valid !== 1'b0 || Lane_Full !== 4'b1101) begin
         bad++;
         $display("FAIL select_partial got=%b/%b required=0/1101", Frame_Valid, Lane_Full);
      end
      exp_q.push_back({4'hC, 4'hA, 4'hD, 4'hB});
      drive(1'b1, 1'b0, 2'd1, 1'b0, 4'hD);
      total++;
      if (Frame_Valid !== 1'b1 || {OUT0, OUT1, OUT2, OUT3} !== 16'hBDAC) begin
         bad++;
         $display("FAIL select_frame got=%b/%h required=1/bdac", Frame_Valid, {OUT0, OUT1, OUT2, OUT3});
      end
   endtask

   task automatic test_overrun_clear();
      drive(1'b1, 1'b0, 2'd1, 1'b0, 4'd5);
      drive(1'b1, 1'b0, 2'd1, 1'b0, 4'd6);
      total++;
      if (OUT1 !== 4'd6 || Overrun !== 1'b1 || Lane_Full !== 4'b0010 || Frame_Valid !== 1'b0) begin
         bad++;
         $display("FAIL overrun got=%h/%b/%b/%b required=6/1/0010/0", OUT1, Overrun, Lane_Full, Frame_Valid);
      end
      drive(1'b0, 1'b0, 2'd0, 1'b1, 4'd0);
      total++;
      if (Overrun !== 1'b0 || Lane_Full !== 4'b0000 || OUT1 !== 4'd6) begin
         bad++;
         $display("FAIL overrun_clear got=%b/%b/%h required=0/0000/6", Overrun, Lane_Full, OUT1);
      end
   endtask

   task automatic test_clear_drop();
      drive(1'b1, 1'b1, 2'd0, 1'b0, 4'd7);
      drive(1'b1, 1'b1, 2'd0, 1'b0, 4'd8);
      drive(1'b1, 1'b1, 2'd0, 1'b1, 4'd9);
      total++;
      if (Lane_Full !== 4'b0000 || OUT2 !== 4'hA || {OUT0, OUT1} !== 8'h78) begin
         bad++;
         $display("FAIL clear_drop got=%b/%h/%h required=0000/a/78", Lane_Full, OUT2, {OUT0, OUT1});
      end
      drive(1'b1, 1'b1, 2'd0, 1'b0, 4'd3);
      total++;
      if (OUT0 !== 4'd3 || Lane_Full !== 4'b0001) begin
         bad++;
         $display("FAIL clear_ptr got=%h/%b required=3/0001", OUT0, Lane_Full);
      end
   endtask

   task automatic test_reset_midframe();
      drive(1'b0, 1'b1, 2'd0, 1'b1, 4'd0);
      drive(1'b1, 1'b1, 2'd0, 1'b0, 4'd1);
      drive(1'b1, 1'b1, 2'd0, 1'b0, 4'd2);
      drive(1'b1, 1'b1, 2'd0, 1'b0, 4'd3);
      Reset = 1'b1;
      #1;
      total++;
      if ({OUT3, OUT2, OUT1, OUT0, Lane_Full, Frame_Valid, Overrun} !== 22'd0) begin
         bad++;
         $display("FAIL reset_async got=%h required=0",
                  {OUT3, OUT2, OUT1, OUT0, Lane_Full, Frame_Valid, Overrun});
      end
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      drive(1'b1, 1'b1, 2'd0, 1'b0, 4'hC);
      drive(1'b1, 1'b1, 2'd0, 1'b0, 4'hD);
      drive(1'b1, 1'b1, 2'd0, 1'b0, 4'hE);
      exp_q.push_back({4'hF, 4'hE, 4'hD, 4'hC});
      drive(1'b1, 1'b1, 2'd0, 1'b0, 4'hF);
      total++;
      if (Frame_Valid !== 1'b1 || {OUT0, OUT1, OUT2, OUT3} !== 16'hCDEF) begin
         bad++;
         $display("FAIL reset_then_frame got=%b/%h required=1/cdef", Frame_Valid, {OUT0, OUT1, OUT2, OUT3});
      end
   endtask

   initial begin
      Reset    = 1'b1;
      IN       = '0;
      IN_Valid = 1'b0;
      Auto     = 1'b0;
      Select   = '0;
      Clear    = 1'b0;
      test_reset();
      test_auto_frame();
      test_back_to_back();
      test_select();
      test_overrun_clear();
      test_clear_drop();
      test_reset_midframe();
      repeat (2) @(posedge Clock);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL frames_missing got=%0d required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/demux4_deser.md
# demux4_deser

Four-lane registered demultiplexer/deserializer: steers a single input word stream onto four registered output lanes, either round-robin or by explicit lane select, and flags when a complete four-word frame is held. It is the receiving end for streams built by the four-input registered multiplexer: words serialized through that mux are reassembled here into parallel lanes.

## Interface
- bw_in, 4, data word width in bits (≥1)
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- IN  input  bw_in  incoming data word
- IN_Valid  input  1  IN is written this cycle
- Auto  input  1  1 = round-robin lane pointer; 0 = lane from Select
- Select  input  2  target lane when Auto=0
- Clear  input  1  synchronous clear of lane flags, pointer, Overrun
- OUT0..OUT3  output  bw_in each  registered lane data
- Lane_Full  output  4  bit n set = lane n written since last frame/clear
- Frame_Valid  output  1  one-cycle pulse: OUT0..OUT3 hold a complete frame
- Overrun  output  1  sticky: a full lane was rewritten before frame completion

## Operation
- Reset values: OUT0..OUT3 = 0, Lane_Full = 4'b0000, Frame_Valid = 0, Overrun = 0, internal pointer = 0.
- Target lane per cycle: pointer when Auto=1, Select when Auto=0; Auto sampled every cycle.
- Write (IN_Valid=1, Clear=0): OUTtarget <= IN; Lane_Full[target] <= 1.
- Auto=1 write: pointer <= pointer+1, 2-bit wrap 3→0. Auto=0 write: pointer unchanged.
- Frame completion: if the write makes all four Lane_Full bits 1 (existing OR new bit), then Frame_Valid <= 1 and Lane_Full <= 0 on the same edge; pointer still advances per above (auto frame ends at 3→0).
- Overrun: write to a lane whose Lane_Full bit is already 1 sets Overrun (sticky); data is still overwritten; the write cannot complete a frame unless the other three bits are set.
- Clear=1: Lane_Full <= 0, pointer <= 0, Overrun <= 0, Frame_Valid <= 0; OUT0..OUT3 retain values; a simultaneous IN_Valid write is dropped (Clear wins).
- IN_Valid=0: no register changes except Frame_Valid <= 0.
- Reset asserted mid-frame: everything returns to reset values immediately; no Frame_Valid.

## Timing
- Write latency 1 cycle: word on IN at edge k appears on OUTn after edge k.
- Frame_Valid asserted for exactly the cycle after the completing write edge; all four OUT registers hold the complete frame during that cycle.
- Back-to-back frames: full throughput, one word per cycle; Frame_Valid pulses every 4th cycle in continuous auto mode.
- A write in the Frame_Valid cycle starts the next frame; it alters OUT data only after the following edge.
- No combinational path from inputs to outputs.

## Structure
- Shared package: NUM_LANES = 4, LANE_W = 2, lane index typedef, FRAME_FULL = 4'b1111 constant.
- One natural sub-module: demux4_lane (per-lane data register + full flag, write-enable and clear inputs), instantiated four times; pointer, frame detect and Overrun live in the top.

## Test plan
- Reset then Auto=1, IN_Valid=1 for 4 cycles with IN=1,2,3,4 -> OUT0..3 = 1,2,3,4; Frame_Valid high one cycle after 4th write; Lane_Full=0 in that cycle.
- Continuous Auto=1 stream 1..12 -> three Frame_Valid pulses spaced 4 cycles; OUT0..3 = 9,10,11,12 at end; Overrun=0.
- Auto=0, Select=2,0,3,1 with IN=A,B,C,D -> OUT0..3 = B,D,A,C; Frame_Valid after the write to lane 1.
- Auto=0, Select=1 twice (IN=5 then 6) -> OUT1=6, Overrun=1, Lane_Full=4'b0010, no Frame_Valid; Clear -> Overrun=0, Lane_Full=0, OUT1 still 6.
- Clear and IN_Valid same cycle after two auto writes -> write dropped, pointer=0; next write lands in OUT0.
- Reset asserted after 3 auto writes -> all outputs 0 immediately; subsequent 4 writes produce one normal frame.
